int2float_seq: RTL and testbench



---
 rtl/int2float_if.sv | 33 +++
 rtl/int2float_seq.sv | 95 +++++++++
 tb/tb_int2float_seq.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/int2float_if.sv
//------------------------------------------------------------------------------
// int2float_if
// Input and result handshakes of the sequential integer-to-binary32 converter.
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

interface int2float_if;
  logic        in_valid;
  logic        in_ready;
  logic        sign_in;
  logic [30:0] int_in;
  logic        out_valid;
  logic        out_ready;
  logic        sign_out;
  logic [7:0]  exponent_out;
  logic [22:0] mantissa_out;
  logic        inexact;

  // Producer/consumer side
  modport master (
    output in_valid, sign_in, int_in, out_ready,
    input  in_ready, out_valid, sign_out, exponent_out, mantissa_out, inexact
  );

  // Converter side
  modport slave (
    input  in_valid, sign_in, int_in, out_ready,
    output in_ready, out_valid, sign_out, exponent_out, mantissa_out, inexact
  );
endinterface

`default_nettype wire

// File: rtl/int2float_seq.sv
//------------------------------------------------------------------------------
// int2float_seq
// Sign-magnitude integer to IEEE-754 binary32, one normalising shift per cycle,
// truncating rounding with an inexact flag.
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module int2float_seq (
  input  wire          clk,
  input  wire          rst_n,
  int2float_if.slave   bus
);

  localparam logic [7:0] C_EXP_TOP = 8'd157;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    NORM = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [30:0] r_norm;
  logic [7:0]  r_exp;
  logic        r_sign;

  logic        w_accept;
  logic        w_zero;
  logic        w_shift;
  logic        w_done;

  assign w_accept = (r_state == IDLE) && bus.in_valid;
  assign w_zero   = (bus.int_in == 31'd0);
  assign w_shift  = (r_state == NORM) && !r_norm[30];
  assign w_done   = (r_state == DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          w_state_nxt = w_zero ? DONE : NORM;
        end
      end
      NORM: begin
        if (r_norm[30]) begin
          w_state_nxt = DONE;
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Zero input leaves norm and exp at zero, which already encodes +/-0.0
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_norm <= 31'd0;
      r_exp  <= 8'd0;
      r_sign <= 1'b0;
    end else if (w_accept) begin
      r_sign <= bus.sign_in;
      r_norm <= bus.int_in;
      r_exp  <= w_zero ? 8'd0 : C_EXP_TOP;
    end else if (w_shift) begin
      r_norm <= {r_norm[29:0], 1'b0};
      r_exp  <= r_exp - 8'd1;
    end
  end

  // Result fields are masked outside DONE so no partial value is ever visible
  assign bus.in_ready     = (r_state == IDLE);
  assign bus.out_valid    = w_done;
  assign bus.sign_out     = w_done ? r_sign : 1'b0;
  assign bus.exponent_out = w_done ? r_exp : 8'd0;
  assign bus.mantissa_out = w_done ? r_norm[29:7] : 23'd0;
  assign bus.inexact      = w_done ? (|r_norm[6:0]) : 1'b0;

endmodule

`default_nettype wire

// File: tb/tb_int2float_seq.sv
//------------------------------------------------------------------------------
// tb_int2float_seq
// Directed vectors with hand-computed binary32 results plus handshake corners.
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_int2float_seq;

  typedef struct {
    logic        sign;
    logic [30:0] val;
    int          lat;
    logic [7:0]  exp_e;
    logic [22:0] man_e;
    logic        inx_e;
  } vec_t;

  logic clk;
  logic rst_n;
  int   n_vec;
  int   n_err;

  int2float_if bus ();

  int2float_seq dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, required to finish");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
    end
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!bus.in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
  endtask

  // Present one word, measure latency from the accepting edge, check fields
  task automatic run_vec(input vec_t v, input string tag, input bit do_hs);
    int n;
    @(negedge clk);
    wait_ready();
    bus.in_valid = 1'b1;
    bus.sign_in  = v.sign;
    bus.int_in   = v.val;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    n = 0;
    while (!bus.out_valid && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    chk({tag, " latency"}, 32'(n), 32'(v.lat));
    chk({tag, " sign"}, 32'(bus.sign_out), 32'(v.sign));
    chk({tag, " exponent"}, 32'(bus.exponent_out), 32'(v.exp_e));
    chk({tag, " mantissa"}, 32'(bus.mantissa_out), 32'(v.man_e));
    chk({tag, " inexact"}, 32'(bus.inexact), 32'(v.inx_e));
    if (do_hs) begin
      @(posedge clk); #1;
      chk({tag, " out_valid after handshake"}, 32'(bus.out_valid), 32'd0);
      chk({tag, " in_ready after handshake"}, 32'(bus.in_ready), 32'd1);
    end
  endtask

  vec_t vecs[10];
  vec_t v;

  initial begin
    n_vec = 0;
    n_err = 0;
    rst_n = 1'b0;
    bus.in_valid  = 1'b0;
    bus.sign_in   = 1'b0;
    bus.int_in    = 31'd0;
    bus.out_ready = 1'b1;

    vecs[0] = '{1'b0, 31'h00000001, 31, 8'h7F, 23'h000000, 1'b0};
    vecs[1] = '{1'b1, 31'h00000005, 29, 8'h81, 23'h200000, 1'b0};
    vecs[2] = '{1'b0, 31'h7FFFFFFF,  1, 8'h9D, 23'h7FFFFF, 1'b1};
    vecs[3] = '{1'b0, 31'h40000000,  1, 8'h9D, 23'h000000, 1'b0};
    vecs[4] = '{1'b1, 31'h00000000,  0, 8'h00, 23'h000000, 1'b0};
    vecs[5] = '{1'b0, 31'h12345678,  3, 8'h9B, 23'h11A2B3, 1'b1};
    vecs[6] = '{1'b1, 31'h00000081, 24, 8'h86, 23'h010000, 1'b0};
    vecs[7] = '{1'b0, 31'h7FFFFF80,  1, 8'h9D, 23'h7FFFFF, 1'b0};
    vecs[8] = '{1'b0, 31'h3FFFFFFF,  2, 8'h9C, 23'h7FFFFF, 1'b1};
    vecs[9] = '{1'b0, 31'h00000300, 22, 8'h88, 23'h400000, 1'b0};

    repeat (3) @(posedge clk);
    #1;
    chk("reset in_ready", 32'(bus.in_ready), 32'd1);
    chk("reset out_valid", 32'(bus.out_valid), 32'd0);
    chk("reset result", {bus.sign_out, bus.exponent_out, bus.mantissa_out}, 32'd0);
    chk("reset inexact", 32'(bus.inexact), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 10; i++) begin
      run_vec(vecs[i], $sformatf("vec%0d", i), 1'b1);
    end

    // Backpressure: result held, busy block ignores a second word
    bus.out_ready = 1'b0;
    run_vec(vecs[9], "bp", 1'b0);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.sign_in  = 1'b1;
      bus.int_in   = 31'h00000001;
      @(posedge clk); #1;
      chk($sformatf("bp hold%0d", i),
          {bus.out_valid, bus.in_ready, bus.exponent_out, bus.mantissa_out[22:1]},
          {1'b1, 1'b0, 8'h88, 22'h200000});
    end
    @(negedge clk);
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp out_valid after release", 32'(bus.out_valid), 32'd0);
    chk("bp in_ready after release", 32'(bus.in_ready), 32'd1);
    repeat (3) @(posedge clk);
    #1;
    chk("bp no extra result", 32'(bus.out_valid), 32'd0);

    // Asynchronous reset in the middle of normalisation
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.sign_in  = 1'b1;
    bus.int_in   = 31'h00000001;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    chk("mid-norm busy", 32'(bus.in_ready), 32'd0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async rst in_ready", 32'(bus.in_ready), 32'd1);
    chk("async rst out_valid", 32'(bus.out_valid), 32'd0);
    chk("async rst result",
        {bus.sign_out, bus.exponent_out, bus.mantissa_out, bus.inexact}, 33'd0);
    @(negedge clk);
    rst_n = 1'b1;
    v = '{1'b0, 31'h00000002, 30, 8'h80, 23'h000000, 1'b0};
    run_vec(v, "post-reset", 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
